// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - scrolling pipe field with LFSR gaps, bird collision and pass score
module pipe_field #(
  parameter int         BIRD_COL     = 2,
  parameter int         GAP_H        = 4,
  parameter int         PIPE_SPACING = 5,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkG,
  input  logic        key,
  input  logic [15:0] lights,
  input  logic [3:0]  col_sel,
  output logic [15:0] col_data,
  output logic        gameover,
  output logic [7:0]  score
);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam int          MAXR     = 16 - GAP_H;
  localparam logic [15:0] GAP_MASK = 16'((32'd1 << GAP_H) - 32'd1);

  state_t      state, state_nxt;
  logic [15:0] col [16];
  logic [7:0]  lfsr;
  logic [7:0]  spcnt;
  logic        clkg_q;
  logic        tick;
  logic        collide;
  logic        advance;
  logic [3:0]  r;
  logic [3:0]  row;
  logic [15:0] pipe;

  assign tick    = clkG & ~clkg_q;
  assign collide = (state == RUN) && ((lights & col[BIRD_COL]) != 16'h0000);
  // Collision outranks a coincident tick: the field freezes as it was when hit.
  assign advance = (state == RUN) && tick && !collide;

  assign r    = lfsr[3:0];
  assign row  = (r > 4'(MAXR)) ? r - 4'(MAXR + 1) : r;
  assign pipe = ~(GAP_MASK << row);

  assign col_data = col[col_sel];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key) state_nxt = RUN;
      RUN:     if (collide) state_nxt = OVER;
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gameover = (state == OVER);
  end

  // clkG_q resets high so a strobe already high at reset release is not a tick.
  always_ff @(posedge clk) begin
    if (reset) clkg_q <= 1'b1;
    else       clkg_q <= clkG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) col[i] <= 16'h0000;
      lfsr  <= LFSR_SEED;
      spcnt <= 8'd0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) col[i] <= col[i+1];
      col[15] <= (spcnt == 8'd0) ? pipe : 16'h0000;
      spcnt   <= (spcnt == 8'(PIPE_SPACING - 1)) ? 8'd0 : spcnt + 8'd1;
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      score <= 8'd0;
    else if (advance && (col[BIRD_COL] != 16'h0000) && (score != 8'hFF))
      score <= score + 8'd1;
  end

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - directed self-checking bench for pipe_field
module tb_pipe_field;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clkG = 1'b0;
  logic        key = 1'b0;
  logic [15:0] lights = 16'h0000;
  logic [3:0]  col_sel = 4'd0;
  logic [15:0] col_data;
  logic        gameover;
  logic [7:0]  score;

  int n_cmp = 0;
  int n_err = 0;

  pipe_field dut (
    .clk      (clk),
    .reset    (reset),
    .clkG     (clkG),
    .key      (key),
    .lights   (lights),
    .col_sel  (col_sel),
    .col_data (col_data),
    .gameover (gameover),
    .score    (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    clkG = 1'b1;
    step();
    clkG = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic col_chk(input string tag, input int c, input logic [15:0] exp);
    col_sel = 4'(c);
    #1;
    check(tag, col_data, exp);
  endtask

  task automatic all_zero(input string tag);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int c = 0; c < 16; c++) begin
      col_sel = 4'(c);
      #1;
      acc = acc | col_data;
    end
    check(tag, acc, 16'h0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clkG  = 1'b0;
    key   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start();
    key = 1'b1;
    step();
    key = 1'b0;
  endtask

  initial begin
    // Reset and idle behaviour
    do_reset();
    check("rst_gameover", 16'(gameover), 16'h0);
    check("rst_score", 16'(score), 16'h0);
    all_zero("rst_field");
    ticks(5);
    all_zero("idle_ticks_field");
    check("idle_gameover", 16'(gameover), 16'h0);

    // First pipe from seed A5: row 5 -> FE1F
    lights = 16'h0040;
    start();
    do_tick();
    col_chk("t1_col15", 15, 16'hFE1F);
    col_chk("t1_col14", 14, 16'h0000);
    col_chk("t1_col0", 0, 16'h0000);

    // Held-high clkG is exactly one tick
    clkG = 1'b1;
    repeat (10) step();
    clkG = 1'b0;
    step();
    col_chk("held_col14", 14, 16'hFE1F);
    col_chk("held_col13", 13, 16'h0000);
    col_chk("held_col15", 15, 16'h0000);

    do_tick();
    col_chk("t3_col13", 13, 16'hFE1F);

    // Second pipe at tick 6 from lfsr A9 (row 9), third at tick 11 from 3B (row 11)
    ticks(3);
    col_chk("t6_col15", 15, 16'hE1FF);
    col_chk("t6_col10", 10, 16'hFE1F);
    ticks(5);
    col_chk("t11_col15", 15, 16'h87FF);

    ticks(3);
    col_chk("t14_col2", 2, 16'hFE1F);
    check("t14_gameover", 16'(gameover), 16'h0);
    check("t14_score", 16'(score), 16'h0);
    do_tick();
    check("t15_score", 16'(score), 16'h1);
    check("t15_gameover", 16'(gameover), 16'h0);
    col_chk("t15_col1", 1, 16'hFE1F);

    // Reset mid-run clears everything and returns to IDLE
    do_reset();
    all_zero("midrst_field");
    check("midrst_score", 16'(score), 16'h0);
    check("midrst_gameover", 16'(gameover), 16'h0);
    ticks(2);
    all_zero("midrst_idle_field");
    lights = 16'h0000;
    start();
    do_tick();
    col_chk("restart_col15", 15, 16'hFE1F);

    // lights==0 never collides; then collision coincident with a tick
    ticks(13);
    col_chk("nolight_col2", 2, 16'hFE1F);
    check("nolight_gameover", 16'(gameover), 16'h0);
    lights = 16'h0001;
    clkG   = 1'b1;
    step();
    check("hit_gameover", 16'(gameover), 16'h1);
    col_chk("hit_col2_noshift", 2, 16'hFE1F);
    col_chk("hit_col1", 1, 16'h0000);
    check("hit_score", 16'(score), 16'h0);
    clkG = 1'b0;
    step();
    ticks(4);
    start();
    ticks(2);
    col_chk("over_col2", 2, 16'hFE1F);
    col_chk("over_col15", 15, 16'h0000);
    check("over_score", 16'(score), 16'h0);
    check("over_gameover", 16'(gameover), 16'h1);

    // Score counting and saturation with lights off
    do_reset();
    lights = 16'h0000;
    start();
    ticks(100);
    check("score_100", 16'(score), 16'd18);
    ticks(1200);
    check("score_sat", 16'(score), 16'd255);
    check("sat_gameover", 16'(gameover), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
